// File: rtl/button_pulse_conditioner.sv
// Raw push-button conditioner: synchroniser, debounce FSM and hold timer,
// producing a debounced level plus single-cycle press and long-press events.
module button_pulse_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 2_000_000,
  parameter int LONG_PRESS_CYCLES = 300_000_000,
  parameter int CNT_WIDTH         = 29
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  input  logic enable,
  output logic toggle_signal,
  output logic long_press,
  output logic btn_level
);

  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [2:0] {
    RELEASED,
    CONFIRM_PRESS,
    HELD,
    LONG_HELD,
    CONFIRM_RELEASE
  } state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   dcnt, dcnt_n;
  logic [CNT_WIDTH-1:0]   hcnt, hcnt_n;
  logic                   from_long, from_long_n;
  logic                   btn_level_n;
  logic                   toggle_n;
  logic                   long_n;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;

  // Increment that stops at its limit, so a counter can never wrap.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic [CNT_WIDTH-1:0] lim);
    return (v >= lim) ? lim : v + CNT_WIDTH'(1);
  endfunction

  // Stage p0..pN: metastability chain; only the last stage feeds the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Stage: FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= RELEASED;
      dcnt          <= '0;
      hcnt          <= '0;
      from_long     <= 1'b0;
      btn_level     <= 1'b0;
      toggle_signal <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      dcnt          <= dcnt_n;
      hcnt          <= hcnt_n;
      from_long     <= from_long_n;
      btn_level     <= btn_level_n;
      toggle_signal <= toggle_n;
      long_press    <= long_n;
    end
  end

  always_comb begin
    state_n     = state;
    dcnt_n      = dcnt;
    hcnt_n      = hcnt;
    from_long_n = from_long;
    btn_level_n = btn_level;
    toggle_n    = 1'b0;
    long_n      = 1'b0;

    case (state)
      RELEASED: begin
        if (s) begin
          state_n = CONFIRM_PRESS;
          dcnt_n  = '0;
        end
      end

      CONFIRM_PRESS: begin
        if (!s) begin
          state_n = RELEASED;
        end else if (dcnt == DEB_LAST) begin
          state_n     = HELD;
          btn_level_n = 1'b1;
          toggle_n    = enable;
          hcnt_n      = '0;
        end else begin
          dcnt_n = sat_inc(dcnt, DEB_LAST);
        end
      end

      HELD: begin
        if (!s) begin
          state_n     = CONFIRM_RELEASE;
          from_long_n = 1'b0;
          dcnt_n      = '0;
        end else if (hcnt == HOLD_LAST) begin
          state_n = LONG_HELD;
          long_n  = enable;
        end else begin
          hcnt_n = sat_inc(hcnt, HOLD_LAST);
        end
      end

      LONG_HELD: begin
        if (!s) begin
          state_n     = CONFIRM_RELEASE;
          from_long_n = 1'b1;
          dcnt_n      = '0;
        end
      end

      CONFIRM_RELEASE: begin
        // A bounce back to 1 resumes the hold; hcnt stays frozen meanwhile.
        if (s) begin
          state_n = from_long ? LONG_HELD : HELD;
        end else if (dcnt == DEB_LAST) begin
          state_n     = RELEASED;
          btn_level_n = 1'b0;
        end else begin
          dcnt_n = sat_inc(dcnt, DEB_LAST);
        end
      end

      default: begin
        state_n = RELEASED;
      end
    endcase
  end

endmodule
